regfile_bypass_sb: RTL and testbench

- Parametrised successor to the 16x16 register file used by the single-cycle CPU.
- Provides configurable width and depth, 2 read ports and 1 write port, with register 0 hardwired to zero.
- Adds an internal write-to-read bypass, an optional registered-read mode, and a per-register pending-write scoreboard.
- Sits between the decode stage (reads, issue) and writeback (writes) of the pipelined core.

---
 rtl/regfile_bypass_sb.sv | 62 ++++++
 tb/tb_regfile_bypass_sb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: parametrised 2R1W register file with write bypass and pending-write scoreboard
// r0 reads as zero; READ_LAT selects combinational (0) or registered (1) read data.
module regfile_bypass_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int READ_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    src_reg1,
    input  logic [ADDR_W-1:0]    src_reg2,
    output logic [DATA_W-1:0]    src_data1,
    output logic [DATA_W-1:0]    src_data2,
    input  logic [ADDR_W-1:0]    dst_reg,
    input  logic                 write_reg,
    input  logic [DATA_W-1:0]    dst_data,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_reg,
    output logic                 busy1,
    output logic                 busy2,
    output logic [2**ADDR_W-1:0] busy_vec
);
    localparam int NREGS = 2**ADDR_W;
    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0] pending, setMask, clrMask;
    logic [DATA_W-1:0] rd1, rd2;
    logic wrHit;
    always_comb begin
        wrHit = write_reg && (dst_reg != '0);
        setMask = issue_valid ? (NREGS'(1) << issue_reg) : '0;
        clrMask = write_reg ? (NREGS'(1) << dst_reg) : '0;
        rd1 = (src_reg1 == '0) ? '0 : (wrHit && dst_reg == src_reg1) ? dst_data : mem[src_reg1];
        rd2 = (src_reg2 == '0) ? '0 : (wrHit && dst_reg == src_reg2) ? dst_data : mem[src_reg2];
        // a writeback landing this cycle is forwarded, so it already satisfies the hazard
        busy1 = pending[src_reg1] && !(write_reg && dst_reg == src_reg1);
        busy2 = pending[src_reg2] && !(write_reg && dst_reg == src_reg2);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
            pending <= '0;
        end else begin
            if (wrHit) mem[dst_reg] <= dst_data;
            pending <= ((pending & ~clrMask) | setMask) & ~NREGS'(1);
        end
    assign busy_vec = pending;
    generate
        if (READ_LAT == 1) begin : gReg
            always_ff @(posedge clk or negedge rst)
                if (!rst) begin
                    src_data1 <= '0;
                    src_data2 <= '0;
                end else begin
                    src_data1 <= rd1;
                    src_data2 <= rd2;
                end
        end else begin : gComb
            assign src_data1 = rd1;
            assign src_data2 = rd2;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb_regfile_bypass_sb: checks combinational and registered-read instances side by side
// against a behavioural register/scoreboard model; registered reads go through a queue.
module tb_regfile_bypass_sb;
    logic clk = 0, rst = 0;
    logic [3:0] src_reg1 = 0, src_reg2 = 0, dst_reg = 0, issue_reg = 0;
    logic write_reg = 0, issue_valid = 0;
    logic [15:0] dst_data = 0;
    logic [15:0] d0a, d0b, d1a, d1b;
    logic b0a, b0b, b1a, b1b;
    logic [15:0] bv0, bv1;
    typedef struct packed { logic [15:0] d1; logic [15:0] d2; } pair_t;
    pair_t q[$];
    logic [15:0] mdl [16];
    logic [15:0] mdlSb;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    regfile_bypass_sb #(.DATA_W(16), .ADDR_W(4), .READ_LAT(0)) u0 (
        .clk(clk), .rst(rst), .src_reg1(src_reg1), .src_reg2(src_reg2),
        .src_data1(d0a), .src_data2(d0b), .dst_reg(dst_reg), .write_reg(write_reg),
        .dst_data(dst_data), .issue_valid(issue_valid), .issue_reg(issue_reg),
        .busy1(b0a), .busy2(b0b), .busy_vec(bv0));
    regfile_bypass_sb #(.DATA_W(16), .ADDR_W(4), .READ_LAT(1)) u1 (
        .clk(clk), .rst(rst), .src_reg1(src_reg1), .src_reg2(src_reg2),
        .src_data1(d1a), .src_data2(d1b), .dst_reg(dst_reg), .write_reg(write_reg),
        .dst_data(dst_data), .issue_valid(issue_valid), .issue_reg(issue_reg),
        .busy1(b1a), .busy2(b1b), .busy_vec(bv1));

    function automatic logic [15:0] expRead(input logic [3:0] idx);
        if (idx == 0) return 16'h0000;
        if (write_reg && dst_reg == idx) return dst_data;
        return mdl[idx];
    endfunction

    function automatic logic expBusy(input logic [3:0] idx);
        if (write_reg && dst_reg == idx) return 1'b0;
        return mdlSb[idx];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        mdlSb = 16'h0000;
        q.delete();
    endtask

    task automatic idle();
        write_reg = 0;
        issue_valid = 0;
    endtask

    // one clock edge: expected registered-read values queued before, compared after
    task automatic step(input string tag);
        pair_t e;
        q.push_back({expRead(src_reg1), expRead(src_reg2)});
        @(posedge clk);
        if (write_reg && dst_reg != 0) mdl[dst_reg] = dst_data;
        if (write_reg) mdlSb[dst_reg] = 1'b0;
        if (issue_valid && issue_reg != 0) mdlSb[issue_reg] = 1'b1;
        #1;
        e = q.pop_front();
        checks++;
        if (d1a !== e.d1 || d1b !== e.d2) begin
            errors++;
            $display("FAIL %s lat1 read: got %h/%h expected %h/%h", tag, d1a, d1b, e.d1, e.d2);
        end
    endtask

    task automatic test_reset();
        modelReset();
        #1;
        for (int i = 0; i < 16; i++) begin
            src_reg1 = 4'(i);
            src_reg2 = 4'(15 - i);
            #1;
            checks++;
            if (d0a !== 16'h0 || d0b !== 16'h0 || d1a !== 16'h0 || d1b !== 16'h0) begin
                errors++;
                $display("FAIL reset_read idx=%0d: got %h/%h/%h/%h expected 0000", i, d0a, d0b, d1a, d1b);
            end
        end
        checks++;
        if (bv0 !== 16'h0 || bv1 !== 16'h0 || b0a !== 1'b0 || b0b !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %h/%h busy %b%b expected 0000 00", bv0, bv1, b0a, b0b);
        end
        @(negedge clk) rst = 1;
        step("release");
    endtask

    task automatic test_write();
        write_reg = 1; dst_reg = 5; dst_data = 16'hBEEF; src_reg1 = 5; src_reg2 = 0;
        step("wr5");
        idle();
        #1;
        checks++;
        if (d0a !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_r5: got %h expected beef", d0a);
        end
        step("rd5");
        write_reg = 1; dst_reg = 0; dst_data = 16'h1234; src_reg1 = 0; src_reg2 = 0;
        #1;
        checks++;
        if (d0a !== 16'h0 || d0b !== 16'h0) begin
            errors++;
            $display("FAIL bypass_r0: got %h/%h expected 0000", d0a, d0b);
        end
        step("wr0");
        idle();
        #1;
        checks++;
        if (d0a !== 16'h0) begin
            errors++;
            $display("FAIL read_r0: got %h expected 0000", d0a);
        end
        step("rd0");
    endtask

    task automatic test_bypass();
        write_reg = 1; dst_reg = 7; dst_data = 16'hA5A5; src_reg1 = 7; src_reg2 = 7;
        #1;
        checks++;
        if (d0a !== 16'hA5A5 || d0b !== 16'hA5A5) begin
            errors++;
            $display("FAIL bypass_lat0: got %h/%h expected a5a5", d0a, d0b);
        end
        step("byp7");
        checks++;
        if (d1a !== 16'hA5A5 || d1b !== 16'hA5A5) begin
            errors++;
            $display("FAIL bypass_lat1: got %h/%h expected a5a5", d1a, d1b);
        end
        idle();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_reg = 3; src_reg1 = 3; src_reg2 = 3;
        step("iss3");
        idle();
        #1;
        checks++;
        if (bv0[3] !== 1'b1 || bv1[3] !== 1'b1 || b0a !== 1'b1 || b0b !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_issue: got vec %h busy %b%b expected bit3 set, busy 11", bv0, b0a, b0b);
        end
        write_reg = 1; dst_reg = 3; dst_data = 16'h0042;
        #1;
        checks++;
        if (b0a !== 1'b0 || b1b !== 1'b0 || d0a !== 16'h0042 || bv0[3] !== 1'b1) begin
            errors++;
            $display("FAIL wb_forward: got busy %b%b data %h vec %h expected 00 0042 bit3 set", b0a, b1b, d0a, bv0);
        end
        step("wb3");
        idle();
        #1;
        checks++;
        if (bv0 !== 16'h0 || b0a !== 1'b0) begin
            errors++;
            $display("FAIL busy_cleared: got vec %h busy %b expected 0000 0", bv0, b0a);
        end
        issue_valid = 1; issue_reg = 0; src_reg1 = 0;
        step("iss0");
        idle();
        #1;
        checks++;
        if (bv0 !== 16'h0 || b0a !== 1'b0) begin
            errors++;
            $display("FAIL issue_r0: got vec %h busy %b expected 0000 0", bv0, b0a);
        end
    endtask

    task automatic test_issue_wins();
        issue_valid = 1; issue_reg = 9;
        step("iss9");
        write_reg = 1; dst_reg = 9; dst_data = 16'h0099; src_reg2 = 9;
        #1;
        checks++;
        if (b0b !== 1'b0 || d0b !== 16'h0099) begin
            errors++;
            $display("FAIL issue_wb_same_cycle: got busy %b data %h expected 0 0099", b0b, d0b);
        end
        step("iss_wb9");
        idle();
        #1;
        checks++;
        if (bv0 !== 16'h0200 || bv1 !== 16'h0200 || b0b !== 1'b1 || d0b !== 16'h0099) begin
            errors++;
            $display("FAIL issue_wins: got vec %h/%h busy %b data %h expected 0200 1 0099", bv0, bv1, b0b, d0b);
        end
        issue_valid = 1; issue_reg = 4; write_reg = 1; dst_reg = 9; dst_data = 16'h0101;
        step("iss4_wb9");
        idle();
        #1;
        checks++;
        if (bv0 !== 16'h0010) begin
            errors++;
            $display("FAIL issue_other_wb: got vec %h expected 0010", bv0);
        end
        write_reg = 1; dst_reg = 4; dst_data = 16'h0404;
        step("wb4");
        idle();
    endtask

    task automatic test_async_reset();
        write_reg = 1; dst_reg = 12; dst_data = 16'hFFFF; issue_valid = 1; issue_reg = 12;
        src_reg1 = 12; src_reg2 = 12;
        step("wr12");
        idle();
        #1;
        checks++;
        if (d0a !== 16'hFFFF || b0a !== 1'b1 || d1a !== 16'hFFFF) begin
            errors++;
            $display("FAIL pre_reset_r12: got %h/%h busy %b expected ffff/ffff 1", d0a, d1a, b0a);
        end
        #1 rst = 0;
        modelReset();
        #1;
        checks++;
        if (d0a !== 16'h0 || d0b !== 16'h0 || d1a !== 16'h0 || d1b !== 16'h0) begin
            errors++;
            $display("FAIL async_reset_data: got %h/%h/%h/%h expected 0000", d0a, d0b, d1a, d1b);
        end
        checks++;
        if (bv0 !== 16'h0 || bv1 !== 16'h0 || b0a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_busy: got vec %h/%h busy %b expected 0000 0", bv0, bv1, b0a);
        end
        @(negedge clk) rst = 1;
        step("post_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            write_reg = 1'($urandom_range(0, 1));
            dst_reg = 4'($urandom);
            dst_data = 16'($urandom);
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_reg = 4'($urandom);
            src_reg1 = ($urandom_range(0, 3) == 0) ? dst_reg : 4'($urandom);
            src_reg2 = 4'($urandom);
            #1;
            checks++;
            if (d0a !== expRead(src_reg1) || d0b !== expRead(src_reg2)) begin
                errors++;
                $display("FAIL rand_read n=%0d: got %h/%h expected %h/%h", n, d0a, d0b, expRead(src_reg1), expRead(src_reg2));
            end
            checks++;
            if (b0a !== expBusy(src_reg1) || b1b !== expBusy(src_reg2) || bv0 !== mdlSb || bv1 !== mdlSb) begin
                errors++;
                $display("FAIL rand_busy n=%0d: got %b%b vec %h/%h expected %b%b vec %h", n, b0a, b1b, bv0, bv1, expBusy(src_reg1), expBusy(src_reg2), mdlSb);
            end
            step("rand");
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_issue_wins();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
